// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART RX command sequencer: opcodes, FSM states,
// legal prescale values and the prescale legality helper.
package uart_ctrl_pkg;

    localparam logic [7:0] WR_CMD  = 8'hAA;
    localparam logic [7:0] RD_CMD  = 8'hBB;
    localparam logic [7:0] CFG_CMD = 8'hCC;

    localparam logic [5:0] PRESCALE_8       = 6'd8;
    localparam logic [5:0] PRESCALE_16      = 6'd16;
    localparam logic [5:0] PRESCALE_32      = 6'd32;
    localparam logic [5:0] DEFAULT_PRESCALE = PRESCALE_8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND,
        CFG_DATA
    } state_t;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, and holds at
// TERMINAL with done asserted until the next clear.
module uart_cmd_timer #(
    parameter int WIDTH    = 16,
    parameter int TERMINAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != TERM)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign done = (count_reg == TERM);

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Byte-framed command sequencer behind UART_RX: register writes/reads, read
// response over UART TX, and RX configuration. UART_CMD_TIMEOUT_EN adds an inter-byte timeout.
module uart_rx_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_d_valid,
    input  logic                  rx_err,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic                  rf_wr_en,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  rf_rd_en,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_d_valid,
    input  logic                  tx_busy,
    output logic                  cfg_par_en,
    output logic                  cfg_par_type,
    output logic [5:0]            cfg_prescale,
    output logic [7:0]            err_cnt
);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
    logic [DATA_WIDTH-1:0]   tx_data_reg, tx_data_next;
    logic                    wr_en_reg, wr_en_next;
    logic                    rd_en_reg, rd_en_next;
    logic                    par_en_reg, par_en_next;
    logic                    par_type_reg, par_type_next;
    logic [5:0]              prescale_reg, prescale_next;
    logic [7:0]              err_reg, err_next;
    logic                    err_hit;
    logic                    good_byte, bad_byte, addr_ok, resp_phase, timeout;

    assign good_byte  = rx_d_valid && !rx_err;
    assign bad_byte   = rx_d_valid && rx_err;
    assign addr_ok    = (rx_p_data[DATA_WIDTH-1:ADDR_WIDTH] == '0);
    // Once the read is issued the response must complete, so later bytes never abort it.
    assign resp_phase = (state_reg == RD_WAIT) || (state_reg == TX_SEND);

`ifdef UART_CMD_TIMEOUT_EN
    logic timer_done, in_frame;

    assign in_frame = (state_reg == WR_ADDR) || (state_reg == WR_DATA) ||
                      (state_reg == RD_ADDR) || (state_reg == CFG_DATA);

    uart_cmd_timer #(
        .WIDTH    (16),
        .TERMINAL (TIMEOUT_CYC)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_d_valid),
        .en   (in_frame),
        .done (timer_done)
    );

    // A byte arriving on the terminal cycle takes priority over the timeout.
    assign timeout = timer_done && in_frame && !rx_d_valid;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wr_data_next  = wr_data_reg;
        tx_data_next  = tx_data_reg;
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        par_en_next   = par_en_reg;
        par_type_next = par_type_reg;
        prescale_next = prescale_reg;
        err_hit       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (good_byte) begin
                    if (rx_p_data == WR_CMD)       state_next = WR_ADDR;
                    else if (rx_p_data == RD_CMD)  state_next = RD_ADDR;
                    else if (rx_p_data == CFG_CMD) state_next = CFG_DATA;
                    else                           err_hit    = 1'b1;
                end
            end
            WR_ADDR: begin
                if (good_byte) begin
                    if (addr_ok) begin
                        addr_next  = rx_p_data[ADDR_WIDTH-1:0];
                        state_next = WR_DATA;
                    end else begin
                        err_hit    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (good_byte) begin
                    wr_data_next = rx_p_data;
                    wr_en_next   = 1'b1;
                    state_next   = IDLE;
                end
            end
            RD_ADDR: begin
                if (good_byte) begin
                    if (addr_ok) begin
                        addr_next  = rx_p_data[ADDR_WIDTH-1:0];
                        rd_en_next = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        err_hit    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (rx_d_valid) err_hit = 1'b1;
                if (rf_rd_valid) begin
                    tx_data_next = rf_rd_data;
                    state_next   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (rx_d_valid) err_hit = 1'b1;
                if (!tx_busy) state_next = IDLE;
            end
            CFG_DATA: begin
                if (good_byte) begin
                    par_en_next   = rx_p_data[0];
                    par_type_next = rx_p_data[1];
                    if (prescale_legal(rx_p_data[7:2])) prescale_next = rx_p_data[7:2];
                    else                                err_hit       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (bad_byte) begin
            err_hit = 1'b1;
            if (!resp_phase) state_next = IDLE;
        end
        if (timeout) begin
            err_hit    = 1'b1;
            state_next = IDLE;
        end

        err_next = (err_hit && (err_reg != 8'hFF)) ? err_reg + 8'd1 : err_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wr_data_reg  <= '0;
            tx_data_reg  <= '0;
            wr_en_reg    <= 1'b0;
            rd_en_reg    <= 1'b0;
            par_en_reg   <= 1'b0;
            par_type_reg <= 1'b0;
            prescale_reg <= DEFAULT_PRESCALE;
            err_reg      <= 8'd0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wr_data_reg  <= wr_data_next;
            tx_data_reg  <= tx_data_next;
            wr_en_reg    <= wr_en_next;
            rd_en_reg    <= rd_en_next;
            par_en_reg   <= par_en_next;
            par_type_reg <= par_type_next;
            prescale_reg <= prescale_next;
            err_reg      <= err_next;
        end
    end

    // The TX request is combinational so it lands in the first cycle tx_busy is low.
    assign tx_d_valid   = (state_reg == TX_SEND) && !tx_busy;
    assign rf_addr      = addr_reg;
    assign rf_wr_data   = wr_data_reg;
    assign rf_wr_en     = wr_en_reg;
    assign rf_rd_en     = rd_en_reg;
    assign tx_p_data    = tx_data_reg;
    assign cfg_par_en   = par_en_reg;
    assign cfg_par_type = par_type_reg;
    assign cfg_prescale = prescale_reg;
    assign err_cnt      = err_reg;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: table-driven frames plus hand-written
// read/backpressure, timeout, saturation and reset sequences.
module tb_uart_rx_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_p_data = 8'h00;
    logic       rx_d_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [3:0] rf_addr;
    logic       rf_wr_en;
    logic [7:0] rf_wr_data;
    logic       rf_rd_en;
    logic [7:0] rf_rd_data = 8'h00;
    logic       rf_rd_valid = 1'b0;
    logic [7:0] tx_p_data;
    logic       tx_d_valid;
    logic       tx_busy = 1'b0;
    logic       cfg_par_en;
    logic       cfg_par_type;
    logic [5:0] cfg_prescale;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_rx_cmd_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_p_data    (rx_p_data),
        .rx_d_valid   (rx_d_valid),
        .rx_err       (rx_err),
        .rf_addr      (rf_addr),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_data   (rf_wr_data),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_data   (rf_rd_data),
        .rf_rd_valid  (rf_rd_valid),
        .tx_p_data    (tx_p_data),
        .tx_d_valid   (tx_d_valid),
        .tx_busy      (tx_busy),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_type (cfg_par_type),
        .cfg_prescale (cfg_prescale),
        .err_cnt      (err_cnt)
    );

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, overlap_cnt = 0;

    always @(negedge clk) begin
        if (rf_wr_en)   wr_cnt++;
        if (rf_rd_en)   rd_cnt++;
        if (tx_d_valid) tx_cnt++;
        if ((int'(rf_wr_en) + int'(rf_rd_en) + int'(tx_d_valid)) > 1) overlap_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        @(posedge clk); #1;
        rx_p_data  = b;
        rx_d_valid = 1'b1;
        rx_err     = e;
        @(posedge clk); #1;
        rx_d_valid = 1'b0;
        rx_err     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0] n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] e;
        logic       exp_wr;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_err;
        logic       exp_pe;
        logic       exp_pt;
        logic [5:0] exp_pre;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        int wr0, rd0, tx0, err_exp;
        logic [7:0] b;

        //          n     b0     b1     b2     e       wr    addr  data   err    pe    pt    pre
        vecs[0]  = '{2'd3, 8'hAA, 8'h05, 8'h3C, 3'b000, 1'b1, 4'h5, 8'h3C, 8'd0, 1'b0, 1'b0, 6'd8};
        vecs[1]  = '{2'd2, 8'hCC, 8'h43, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd0, 1'b1, 1'b1, 6'd16};
        vecs[2]  = '{2'd2, 8'hCC, 8'h2B, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd1, 1'b1, 1'b1, 6'd16};
        vecs[3]  = '{2'd2, 8'hCC, 8'h80, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd1, 1'b0, 1'b0, 6'd32};
        vecs[4]  = '{2'd2, 8'hCC, 8'h20, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd1, 1'b0, 1'b0, 6'd8};
        vecs[5]  = '{2'd1, 8'h11, 8'h00, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd2, 1'b0, 1'b0, 6'd8};
        vecs[6]  = '{2'd2, 8'hAA, 8'h15, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd3, 1'b0, 1'b0, 6'd8};
        vecs[7]  = '{2'd2, 8'hAA, 8'h33, 8'h00, 3'b010, 1'b0, 4'h0, 8'h00, 8'd4, 1'b0, 1'b0, 6'd8};
        vecs[8]  = '{2'd3, 8'hAA, 8'h02, 8'h01, 3'b000, 1'b1, 4'h2, 8'h01, 8'd4, 1'b0, 1'b0, 6'd8};
        vecs[9]  = '{2'd3, 8'hAA, 8'h0F, 8'hFF, 3'b000, 1'b1, 4'hF, 8'hFF, 8'd4, 1'b0, 1'b0, 6'd8};
        vecs[10] = '{2'd3, 8'hAA, 8'h04, 8'h55, 3'b100, 1'b0, 4'h0, 8'h00, 8'd5, 1'b0, 1'b0, 6'd8};
        vecs[11] = '{2'd2, 8'hCC, 8'h00, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd6, 1'b0, 1'b0, 6'd8};
        vecs[12] = '{2'd1, 8'hAA, 8'h00, 8'h00, 3'b001, 1'b0, 4'h0, 8'h00, 8'd7, 1'b0, 1'b0, 6'd8};
        vecs[13] = '{2'd2, 8'hBB, 8'h20, 8'h00, 3'b000, 1'b0, 4'h0, 8'h00, 8'd8, 1'b0, 1'b0, 6'd8};

        // Reset state
        idle(3);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        check("reset prescale", 32'(cfg_prescale), 32'd8);
        check("reset par_en/type", {30'd0, cfg_par_en, cfg_par_type}, 32'd0);
        check("reset strobes", {29'd0, rf_wr_en, rf_rd_en, tx_d_valid}, 32'd0);
        check("reset addr/wdata/txdata", {12'd0, rf_addr, rf_wr_data, tx_p_data}, 32'd0);
        rst = 1'b1;
        idle(2);

        // Table-driven frames
        for (int i = 0; i < NVEC; i++) begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                b = (k == 0) ? vecs[i].b0 : (k == 1) ? vecs[i].b1 : vecs[i].b2;
                send_byte(b, vecs[i].e[k]);
            end
            check($sformatf("v%0d wr_en next cycle", i), 32'(rf_wr_en), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d cfg next cycle", i),
                  {24'd0, cfg_par_en, cfg_par_type, cfg_prescale},
                  {24'd0, vecs[i].exp_pe, vecs[i].exp_pt, vecs[i].exp_pre});
            idle(3);
            check($sformatf("v%0d wr pulses", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d rd pulses", i), 32'(rd_cnt - rd0), 32'd0);
            check($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            if (vecs[i].exp_wr) begin
                check($sformatf("v%0d addr/data", i), {20'd0, rf_addr, rf_wr_data},
                      {20'd0, vecs[i].exp_addr, vecs[i].exp_data});
            end
        end
        err_exp = 8;

        // Inter-byte stall after a write opcode
        wr0 = wr_cnt;
        send_byte(8'hAA, 1'b0);
        idle(60);
`ifdef UART_CMD_TIMEOUT_EN
        err_exp++;
        check("timeout err_cnt", 32'(err_cnt), 32'(err_exp));
        send_byte(8'hAA, 1'b0);
`else
        check("stall no err", 32'(err_cnt), 32'(err_exp));
`endif
        send_byte(8'h01, 1'b0);
        send_byte(8'h77, 1'b0);
        check("post-stall wr_en", 32'(rf_wr_en), 32'd1);
        idle(2);
        check("post-stall wr pulses", 32'(wr_cnt - wr0), 32'd1);
        check("post-stall addr/data", {20'd0, rf_addr, rf_wr_data}, {20'd0, 4'h1, 8'h77});
        check("post-stall err_cnt", 32'(err_cnt), 32'(err_exp));

        // Read with rf latency 2, TX backpressure and an errored overrun byte
        rd0 = rd_cnt;
        tx0 = tx_cnt;
        tx_busy = 1'b1;
        send_byte(8'hBB, 1'b0);
        send_byte(8'h07, 1'b0);
        check("read rd_en next cycle", 32'(rf_rd_en), 32'd1);
        check("read addr", 32'(rf_addr), 32'h7);
        repeat (2) @(posedge clk);
        #1;
        rf_rd_data  = 8'h9E;
        rf_rd_valid = 1'b1;
        @(posedge clk); #1;
        rf_rd_valid = 1'b0;
        rf_rd_data  = 8'h00;
        send_byte(8'h55, 1'b1);
        err_exp++;
        idle(7);
        check("busy no tx", 32'(tx_cnt - tx0), 32'd0);
        check("tx data held", 32'(tx_p_data), 32'h9E);
        check("overrun+rx_err once", 32'(err_cnt), 32'(err_exp));
        @(posedge clk); #1;
        tx_busy = 1'b0;
        #1;
        check("tx_d_valid first free cycle", 32'(tx_d_valid), 32'd1);
        check("tx_p_data at pulse", 32'(tx_p_data), 32'h9E);
        idle(1);
        check("tx_d_valid drops", 32'(tx_d_valid), 32'd0);
        idle(3);
        check("tx pulses", 32'(tx_cnt - tx0), 32'd1);
        check("rd pulses", 32'(rd_cnt - rd0), 32'd1);

        // err_cnt saturation
        for (int i = 0; i < 260; i++) send_byte(8'h11, 1'b0);
        check("err_cnt saturates", 32'(err_cnt), 32'd255);

        // Reset in RD_WAIT after a non-default config
        send_byte(8'hCC, 1'b0);
        send_byte(8'h83, 1'b0);
        check("cfg 0x83", {24'd0, cfg_par_en, cfg_par_type, cfg_prescale}, {24'd0, 1'b1, 1'b1, 6'd32});
        tx0 = tx_cnt;
        send_byte(8'hBB, 1'b0);
        send_byte(8'h03, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("async reset err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check("reset cfg defaults", {24'd0, cfg_par_en, cfg_par_type, cfg_prescale}, {24'd0, 1'b0, 1'b0, 6'd8});
        check("reset rf_addr", 32'(rf_addr), 32'd0);
        rf_rd_data  = 8'hAB;
        rf_rd_valid = 1'b1;
        @(posedge clk); #1;
        rf_rd_valid = 1'b0;
        idle(5);
        check("no tx after reset", 32'(tx_cnt - tx0), 32'd0);
        check("tx_p_data after reset", 32'(tx_p_data), 32'd0);
        check("err_cnt after reset", 32'(err_cnt), 32'd0);

        check("strobe overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
- Command sequencer behind UART_RX. Consumes received bytes (P_Data / Data_Valid), decodes byte-framed commands, drives register-file read and write strobes, and returns read data through a UART TX byte handshake.
- Owns the RX configuration (Par_En, Par_Type, Prescale) and reprograms it on a config command.
- Sits between the UART RX/TX pair and the system register file in the RX clock domain.

Parameters:
- DATA_WIDTH, 8, byte width of RX/TX/register data.
- ADDR_WIDTH, 4, register-file address width; addr byte bits above ADDR_WIDTH must be zero.
- TIMEOUT_CYC, 1024, max clk cycles allowed between bytes of one frame (used only with the optional feature).

Ports:
- clk  in  1  RX-domain clock.
- rst  in  1  asynchronous active-low reset.
- rx_p_data  in  DATA_WIDTH  received byte (UART_RX P_Data).
- rx_d_valid  in  1  one-cycle pulse, byte valid (UART_RX Data_Valid).
- rx_err  in  1  parity/stop error flag, qualified by rx_d_valid.
- rf_addr  out  ADDR_WIDTH  register address.
- rf_wr_en  out  1  one-cycle write strobe.
- rf_wr_data  out  DATA_WIDTH  write data.
- rf_rd_en  out  1  one-cycle read strobe.
- rf_rd_data  in  DATA_WIDTH  read data.
- rf_rd_valid  in  1  read data valid; any latency of 1 cycle or more.
- tx_p_data  out  DATA_WIDTH  byte to transmit.
- tx_d_valid  out  1  one-cycle TX request.
- tx_busy  in  1  TX busy; no request is issued while it is high.
- cfg_par_en  out  1  drives UART_RX Par_En.
- cfg_par_type  out  1  drives UART_RX Par_Type (1 = odd).
- cfg_prescale  out  6  drives UART_RX Prescale.
- err_cnt  out  8  saturating frame-error counter.

Behaviour:
- Reset values: all strobes 0; rf_addr, rf_wr_data and tx_p_data 0; err_cnt 0; cfg_par_en 0; cfg_par_type 0; cfg_prescale 8; state IDLE.
- Opcodes: 0xAA write (addr, data); 0xBB read (addr); 0xCC config (one byte).
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND, CFG_DATA.
- IDLE, good byte:
  - 0xAA goes to WR_ADDR; 0xBB goes to RD_ADDR; 0xCC goes to CFG_DATA.
  - Any other opcode stays in IDLE and increments err_cnt.
- WR_ADDR: good byte is latched into rf_addr; go to WR_DATA.
- WR_DATA: byte is latched into rf_wr_data. rf_wr_en pulses the cycle after that byte's rx_d_valid. Return to IDLE.
- RD_ADDR: addr is latched. rf_rd_en pulses the cycle after that byte's rx_d_valid. Go to RD_WAIT.
- RD_WAIT: on rf_rd_valid, capture rf_rd_data into tx_p_data; go to TX_SEND.
- TX_SEND:
  - In the first cycle with tx_busy = 0, assert tx_d_valid for 1 cycle; return to IDLE.
  - tx_p_data is stable from capture until that pulse.
- CFG_DATA: byte b decodes as cfg_par_en = b[0], cfg_par_type = b[1], prescale = b[7:2].
  - Prescale is accepted only if it is 8, 16 or 32. Otherwise the previous prescale is kept and err_cnt increments.
  - All three cfg outputs update together the cycle after rx_d_valid. Return to IDLE.
- Address check: addr byte with nonzero bits [7:ADDR_WIDTH] aborts to IDLE, increments err_cnt, and issues no strobe.
- rx_d_valid with rx_err = 1: byte discarded, err_cnt increments, and any in-progress frame aborts to IDLE (IDLE stays IDLE).
- Overrun: a byte arriving in RD_WAIT or TX_SEND is dropped and err_cnt increments; the read response still completes.
- err_cnt saturates at 255. Multiple error causes in the same cycle increment it once.
- rf_wr_en, rf_rd_en and tx_d_valid are never high in the same cycle.
- Reset mid-frame: immediate return to IDLE with reset values. Cfg reverts to defaults.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- With the macro: a 16-bit counter clears on every rx_d_valid and counts in WR_ADDR, WR_DATA, RD_ADDR and CFG_DATA.
  - When it reaches TIMEOUT_CYC, the frame aborts to IDLE and err_cnt increments.
  - If timeout coincides with rx_d_valid, the byte wins (no timeout).
  - RD_WAIT and TX_SEND are never timed out.
- Without the macro: partial frames wait indefinitely; no counter logic is present.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - Opcode constants WR_CMD = 0xAA, RD_CMD = 0xBB, CFG_CMD = 0xCC.
  - The state encoding.
  - Legal prescale constants 8, 16, 32.
  - The default prescale, 8.
- One sub-module, uart_cmd_timer: a clearable, enabled inter-byte timeout counter with a terminal flag. It is instantiated only under UART_CMD_TIMEOUT_EN.

Test Plan:
- Write: bytes 0xAA, 0x05, 0x3C -> one rf_wr_en pulse with rf_addr = 5, rf_wr_data = 0x3C, one cycle after the third rx_d_valid; err_cnt = 0.
- Read with backpressure: bytes 0xBB, 0x07; rf_rd_data = 0x9E after a 2-cycle rf_rd_valid delay; tx_busy held high 10 cycles -> rf_rd_en pulse, then tx_d_valid exactly once with 0x9E, in the first cycle tx_busy = 0.
- Config: bytes 0xCC, 0x43 -> prescale 16, par_type 1, par_en 1 on the same cycle. Then 0xCC, 0x2B (prescale 10) -> prescale stays 16, par_type 1, par_en 1, err_cnt = 1.
- Errors: opcode 0x11 -> err_cnt increments. 0xAA, 0x15 (addr out of range) -> abort, no strobe. 0xAA then a byte with rx_err = 1 -> abort. Following 0xAA, 0x02, 0x01 -> normal write.
- Timeout (macro on, TIMEOUT_CYC = 50): 0xAA then 60 idle cycles -> IDLE, err_cnt increments. Next 0xAA, 0x01, 0x77 -> write. Macro off: the same stall then 0x01, 0x77 -> write to addr 1.
- Reset mid-read in RD_WAIT: rst low 1 cycle -> no tx_d_valid, cfg_prescale = 8, err_cnt = 0.
